// File: rtl/fetch_stage.sv
// IF stage: drives the instruction cache, tracks the PC and owns the IF/ID latch.
// Define FETCH_BUF_EN to add a one-entry buffer that keeps a word returned during a stall.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        redirect,
    input  logic [31:0] PCSrc,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt,
    output logic [31:0] instru,
    output logic [31:0] nPC,
    output logic        valid
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instru;
    logic [31:0] r_npc;
    logic        r_valid;
`ifdef FETCH_BUF_EN
    logic [31:0] r_buf_word;
    logic [31:0] r_buf_npc;
    logic        r_buf_full;
`endif

    logic [31:0] w_pc_inc;
    logic        w_hit;

    assign w_pc_inc = r_pc + 32'd4;
    assign w_hit    = (r_state == FETCH) && ihit;

    assign imemREN  = (r_state == FETCH);
    assign imemaddr = r_pc;
    assign instru   = r_instru;
    assign nPC      = r_npc;
    assign valid    = r_valid;

    // Priority: halt > redirect > flush > stall > normal fetch; HALTED is left only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= FETCH;
            r_pc       <= PC_INIT;
            r_instru   <= 32'd0;
            r_npc      <= 32'd0;
            r_valid    <= 1'b0;
`ifdef FETCH_BUF_EN
            r_buf_word <= 32'd0;
            r_buf_npc  <= 32'd0;
            r_buf_full <= 1'b0;
`endif
        end else if (r_state != HALTED) begin
            if (halt) begin
                r_state  <= HALTED;
                r_instru <= 32'd0;
                r_npc    <= 32'd0;
                r_valid  <= 1'b0;
`ifdef FETCH_BUF_EN
                r_buf_full <= 1'b0;
`endif
            end else if (redirect) begin
                // Any word returned this cycle belongs to the wrong path and is dropped.
                r_state  <= FETCH;
                r_pc     <= PCSrc;
                r_instru <= 32'd0;
                r_npc    <= 32'd0;
                r_valid  <= 1'b0;
`ifdef FETCH_BUF_EN
                r_buf_full <= 1'b0;
`endif
            end else if (flush) begin
                r_state  <= FETCH;
                r_instru <= 32'd0;
                r_npc    <= 32'd0;
                r_valid  <= 1'b0;
                if (w_hit) begin
                    r_pc <= w_pc_inc;
                end
`ifdef FETCH_BUF_EN
                r_buf_full <= 1'b0;
`endif
            end else if (stall) begin
`ifdef FETCH_BUF_EN
                if (w_hit && !r_buf_full) begin
                    r_buf_word <= imemload;
                    r_buf_npc  <= w_pc_inc;
                    r_buf_full <= 1'b1;
                    r_pc       <= w_pc_inc;
                    r_state    <= HOLD;
                end
`endif
            end else if (r_state == HOLD) begin
                // PC already moved past the buffered word when it was captured.
`ifdef FETCH_BUF_EN
                r_instru   <= r_buf_word;
                r_npc      <= r_buf_npc;
                r_valid    <= 1'b1;
                r_buf_full <= 1'b0;
`endif
                r_state <= FETCH;
            end else if (w_hit) begin
                r_instru <= imemload;
                r_npc    <= w_pc_inc;
                r_valid  <= 1'b1;
                r_pc     <= w_pc_inc;
            end else begin
                r_instru <= 32'd0;
                r_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] PCSrc = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        halt = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instru;
    logic [31:0] nPC;
    logic        valid;

`ifdef FETCH_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    always #5 CLK = ~CLK;

    fetch_stage #(.PC_INIT(32'h00000000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
        .PCSrc(PCSrc), .stall(stall), .flush(flush), .halt(halt),
        .instru(instru), .nPC(nPC), .valid(valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic        halted;
        logic        bfull;
        logic [31:0] bword;
        logic [31:0] bnpc;
        logic [31:0] instru;
        logic [31:0] npc;
        logic        valid;
    } mst_t;

    mst_t m;

    function automatic mst_t reset_st();
        mst_t s;
        s = '0;
        return s;
    endfunction

    function automatic mst_t clear_latch(mst_t s);
        mst_t n = s;
        n.instru = 32'd0;
        n.npc    = 32'd0;
        n.valid  = 1'b0;
        n.bfull  = 1'b0;
        return n;
    endfunction

    // One clock of the fetch stage, expressed as its observable effect.
    function automatic mst_t step(mst_t s, logic ih, logic [31:0] ld, logic rd,
                                  logic [31:0] tgt, logic st, logic fl, logic ht);
        mst_t n = s;
        logic got;
        got = !s.bfull && ih;
        if (s.halted) return n;
        if (ht) begin
            n = clear_latch(s);
            n.halted = 1'b1;
        end else if (rd) begin
            n = clear_latch(s);
            n.pc = tgt;
        end else if (fl) begin
            n = clear_latch(s);
            if (got) n.pc = s.pc + 32'd4;
        end else if (st) begin
            if (BUF && got) begin
                n.bfull = 1'b1;
                n.bword = ld;
                n.bnpc  = s.pc + 32'd4;
                n.pc    = s.pc + 32'd4;
            end
        end else if (s.bfull) begin
            n.instru = s.bword;
            n.npc    = s.bnpc;
            n.valid  = 1'b1;
            n.bfull  = 1'b0;
        end else if (got) begin
            n.instru = ld;
            n.npc    = s.pc + 32'd4;
            n.valid  = 1'b1;
            n.pc     = s.pc + 32'd4;
        end else begin
            n.instru = 32'd0;
            n.valid  = 1'b0;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m <= reset_st();
        else       m <= step(m, ihit, imemload, redirect, PCSrc, stall, flush, halt);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model.imemREN",  {31'd0, imemREN}, {31'd0, !m.halted && !m.bfull});
            check("model.imemaddr", imemaddr, m.pc);
            check("model.valid",    {31'd0, valid}, {31'd0, m.valid});
            check("model.instru",   instru, m.instru);
            check("model.nPC",      nPC, m.npc);
        end
    end

    task automatic nxt();
        @(negedge CLK);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        nxt();
        check("rst.valid",   {31'd0, valid}, 32'd0);
        check("rst.instru",  instru, 32'd0);
        check("rst.nPC",     nPC, 32'd0);
        check("rst.imemREN", {31'd0, imemREN}, 32'd1);
        check("rst.imemaddr", imemaddr, 32'h0);
        chk_en = 1'b1;

        nRST = 1'b1; ihit = 1'b1; imemload = 32'h20010005;
        nxt();
        check("seq1.instru", instru, 32'h20010005);
        check("seq1.nPC", nPC, 32'h4);
        check("seq1.valid", {31'd0, valid}, 32'd1);
        check("seq1.imemaddr", imemaddr, 32'h4);
        imemload = 32'h20020007;
        nxt();
        check("seq2.instru", instru, 32'h20020007);
        check("seq2.nPC", nPC, 32'h8);
        check("seq2.imemaddr", imemaddr, 32'h8);

        stall = 1'b1; imemload = 32'hAAAA0008;
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("stall.instru", instru, 32'h20020007);
            check("stall.nPC", nPC, 32'h8);
            check("stall.imemaddr", imemaddr, BUF ? 32'hC : 32'h8);
            check("stall.imemREN", {31'd0, imemREN}, BUF ? 32'd0 : 32'd1);
        end
        stall = 1'b0;
        nxt();
        check("unstall.instru", instru, 32'hAAAA0008);
        check("unstall.nPC", nPC, 32'hC);
        check("unstall.imemaddr", imemaddr, 32'hC);
        imemload = 32'hBBBB000C;
        nxt();
        check("pc10.imemaddr", imemaddr, 32'h10);

        redirect = 1'b1; PCSrc = 32'h40; imemload = 32'hDEADBEEF;
        nxt();
        check("redir.valid", {31'd0, valid}, 32'd0);
        check("redir.instru", instru, 32'd0);
        check("redir.imemaddr", imemaddr, 32'h40);
        redirect = 1'b0; imemload = 32'hCCCC0040;
        nxt();
        check("redir2.instru", instru, 32'hCCCC0040);
        check("redir2.nPC", nPC, 32'h44);

        flush = 1'b1; stall = 1'b1; ihit = 1'b0;
        nxt();
        check("flushstall.valid", {31'd0, valid}, 32'd0);
        check("flushstall.instru", instru, 32'd0);
        flush = 1'b0; stall = 1'b0;

        halt = 1'b1; redirect = 1'b1; PCSrc = 32'h80; ihit = 1'b1;
        nxt();
        check("halt.imemREN", {31'd0, imemREN}, 32'd0);
        check("halt.imemaddr", imemaddr, 32'h44);
        check("halt.valid", {31'd0, valid}, 32'd0);
        halt = 1'b0;
        nxt();
        check("halted.imemaddr", imemaddr, 32'h44);
        check("halted.imemREN", {31'd0, imemREN}, 32'd0);
        redirect = 1'b0; ihit = 1'b0;
        nRST = 1'b0;
        #1;
        check("halt_rst.imemaddr", imemaddr, 32'h0);
        check("halt_rst.imemREN", {31'd0, imemREN}, 32'd1);
        #1 nRST = 1'b1;
        nxt();

        redirect = 1'b1; PCSrc = 32'hFFFFFFFC;
        nxt();
        check("wrap.pre", imemaddr, 32'hFFFFFFFC);
        redirect = 1'b0; ihit = 1'b1; imemload = 32'h12345678;
        nxt();
        check("wrap.nPC", nPC, 32'h0);
        check("wrap.imemaddr", imemaddr, 32'h0);
        check("wrap.instru", instru, 32'h12345678);

        for (int i = 0; i < 1500; i++) begin
            ihit     = ($urandom_range(0, 3) != 0);
            imemload = $urandom;
            redirect = ($urandom_range(0, 9) == 0);
            PCSrc    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            halt     = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 59) == 0) begin
                nRST = 1'b0;
                #1 nRST = 1'b1;
            end
            nxt();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
